// File: rtl/lock_sequencer.sv
// -----------------------------------------------------------------------------
// lock_sequencer
//   Sequencer for a digit-code lock. Turns button presses into one-cycle
//   strobes for an external code register / comparator pair, tracks how many
//   digits have been accepted, counts failed attempts and enforces a timed
//   lockout once the attempts run out.
//
// Ports
//   clk                 system clock, rising edge
//   system_reset        synchronous, active-high reset
//   store_btn           level; each rising edge stores one program digit
//   input_btn           level; each rising edge enters one attempt digit
//   submit_btn          level; each rising edge submits the attempt / closes
//   correct_password    comparator result (level)
//   incorrect_password  comparator result (level)
//   store_value         pulse: latch digit into the system register
//   input_value         pulse: latch digit into the input register
//   compare             pulse: start a compare
//   input_reset         pulse: clear the input register
//   unlock              level: high while OPEN
//   sleep               level: high while LOCKOUT
//   digit_count         digits accepted in the current sequence
//   tries_left          attempts remaining before lockout
//
// State table
//   state        | meaning
//   IDLE         | waiting; store starts programming, input starts an attempt
//   PROGRAM      | collecting program digits
//   ENTRY        | collecting attempt digits
//   CHECK        | issue compare strobe
//   WAIT_RESULT  | waiting for the comparator, bounded by RESULT_TIMEOUT
//   OPEN         | unlocked; submit closes, store reprograms
//   LOCKOUT      | all buttons ignored for LOCK_CYCLES cycles
// -----------------------------------------------------------------------------
module lock_sequencer #(
    parameter int PASS_LEN       = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 50000000,
    parameter int RESULT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       system_reset,
    input  logic       store_btn,
    input  logic       input_btn,
    input  logic       submit_btn,
    input  logic       correct_password,
    input  logic       incorrect_password,
    output logic       store_value,
    output logic       input_value,
    output logic       compare,
    output logic       input_reset,
    output logic       unlock,
    output logic       sleep,
    output logic [2:0] digit_count,
    output logic [1:0] tries_left
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_PROGRAM     = 3'd1;
    localparam logic [2:0] S_ENTRY       = 3'd2;
    localparam logic [2:0] S_CHECK       = 3'd3;
    localparam logic [2:0] S_WAIT_RESULT = 3'd4;
    localparam logic [2:0] S_OPEN        = 3'd5;
    localparam logic [2:0] S_LOCKOUT     = 3'd6;

    // One down-counter serves both the result wait and the lockout, so it is
    // sized for whichever load value is larger.
    localparam int TMAX = (LOCK_CYCLES > RESULT_TIMEOUT) ? LOCK_CYCLES : RESULT_TIMEOUT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'((RESULT_TIMEOUT > 0) ? RESULT_TIMEOUT - 1 : 0);
    localparam logic [2:0]    LEN       = 3'(PASS_LEN);
    localparam logic [1:0]    TRIES     = 2'(MAX_TRIES);

    logic [2:0]    state;
    logic          programmed;
    logic [TW-1:0] timer;
    logic          store_prev;
    logic          input_prev;
    logic          submit_prev;

    logic          ev_store;
    logic          ev_input;
    logic          ev_submit;
    logic          sel_input;
    logic          sel_submit;
    logic [1:0]    tries_dec;

    assign ev_store   = store_btn  & ~store_prev;
    assign ev_input   = input_btn  & ~input_prev;
    assign ev_submit  = submit_btn & ~submit_prev;

    // A higher-priority event masks the lower ones even in states that
    // ignore the higher-priority event.
    assign sel_input  = ev_input  & ~ev_store;
    assign sel_submit = ev_submit & ~ev_store & ~ev_input;

    assign tries_dec  = (tries_left != 2'd0) ? tries_left - 2'd1 : 2'd0;

    assign unlock = (state == S_OPEN);
    assign sleep  = (state == S_LOCKOUT);

    always_ff @(posedge clk) begin
        if (system_reset) begin
            state       <= S_IDLE;
            programmed  <= 1'b0;
            digit_count <= 3'd0;
            tries_left  <= TRIES;
            timer       <= '0;
            store_value <= 1'b0;
            input_value <= 1'b0;
            compare     <= 1'b0;
            input_reset <= 1'b0;
            // Buttons held through reset must not look like fresh presses.
            store_prev  <= store_btn;
            input_prev  <= input_btn;
            submit_prev <= submit_btn;
        end else begin
            store_prev  <= store_btn;
            input_prev  <= input_btn;
            submit_prev <= submit_btn;
            store_value <= 1'b0;
            input_value <= 1'b0;
            compare     <= 1'b0;
            input_reset <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ev_store) begin
                        store_value <= 1'b1;
                        if (LEN == 3'd1) begin
                            programmed  <= 1'b1;
                            digit_count <= 3'd0;
                        end else begin
                            digit_count <= 3'd1;
                            state       <= S_PROGRAM;
                        end
                    end else if (sel_input && programmed) begin
                        input_value <= 1'b1;
                        digit_count <= 3'd1;
                        state       <= S_ENTRY;
                    end
                end

                S_PROGRAM: begin
                    // Completion is taken the cycle after the last digit so
                    // the full count is visible for one cycle.
                    if (digit_count >= LEN) begin
                        programmed  <= 1'b1;
                        digit_count <= 3'd0;
                        state       <= S_IDLE;
                    end else if (ev_store) begin
                        store_value <= 1'b1;
                        digit_count <= digit_count + 3'd1;
                    end
                end

                S_ENTRY: begin
                    if (sel_input) begin
                        if (digit_count < LEN) begin
                            input_value <= 1'b1;
                            digit_count <= digit_count + 3'd1;
                        end
                    end else if (sel_submit) begin
                        if (digit_count == LEN) begin
                            state <= S_CHECK;
                        end else begin
                            input_reset <= 1'b1;
                            tries_left  <= tries_dec;
                            digit_count <= 3'd0;
                            if (tries_dec == 2'd0) begin
                                timer <= LOCK_LOAD;
                                state <= S_LOCKOUT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end

                S_CHECK: begin
                    compare     <= 1'b1;
                    digit_count <= 3'd0;
                    timer       <= WAIT_LOAD;
                    state       <= S_WAIT_RESULT;
                end

                S_WAIT_RESULT: begin
                    if (correct_password && !incorrect_password) begin
                        tries_left <= TRIES;
                        state      <= S_OPEN;
                    end else if (incorrect_password || timer == '0) begin
                        input_reset <= 1'b1;
                        tries_left  <= tries_dec;
                        if (tries_dec == 2'd0) begin
                            timer <= LOCK_LOAD;
                            state <= S_LOCKOUT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                S_OPEN: begin
                    if (ev_store) begin
                        store_value <= 1'b1;
                        if (LEN == 3'd1) begin
                            programmed  <= 1'b1;
                            digit_count <= 3'd0;
                            state       <= S_IDLE;
                        end else begin
                            digit_count <= 3'd1;
                            state       <= S_PROGRAM;
                        end
                    end else if (sel_submit) begin
                        input_reset <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                S_LOCKOUT: begin
                    if (timer == '0) begin
                        tries_left  <= TRIES;
                        input_reset <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lock_sequencer
//   Drives button presses and comparator responses into lock_sequencer and
//   compares against a transaction-level model of the lock (mode, programmed
//   flag, digits entered, attempts remaining).
// -----------------------------------------------------------------------------
module tb_lock_sequencer;

    localparam int PL = 4;
    localparam int MT = 3;
    localparam int LC = 20;
    localparam int RT = 15;

    localparam int M_IDLE  = 0;
    localparam int M_PROG  = 1;
    localparam int M_ENTRY = 2;
    localparam int M_OPEN  = 3;
    localparam int M_LOCK  = 4;

    logic       clk = 1'b0;
    logic       system_reset;
    logic       store_btn;
    logic       input_btn;
    logic       submit_btn;
    logic       correct_password;
    logic       incorrect_password;
    logic       store_value;
    logic       input_value;
    logic       compare;
    logic       input_reset;
    logic       unlock;
    logic       sleep;
    logic [2:0] digit_count;
    logic [1:0] tries_left;

    always #5 clk = ~clk;

    lock_sequencer #(
        .PASS_LEN      (PL),
        .MAX_TRIES     (MT),
        .LOCK_CYCLES   (LC),
        .RESULT_TIMEOUT(RT)
    ) dut (
        .clk               (clk),
        .system_reset      (system_reset),
        .store_btn         (store_btn),
        .input_btn         (input_btn),
        .submit_btn        (submit_btn),
        .correct_password  (correct_password),
        .incorrect_password(incorrect_password),
        .store_value       (store_value),
        .input_value       (input_value),
        .compare           (compare),
        .input_reset       (input_reset),
        .unlock            (unlock),
        .sleep             (sleep),
        .digit_count       (digit_count),
        .tries_left        (tries_left)
    );

    int checks   = 0;
    int failures = 0;

    // pulse tallies, sampled on the rising edge (pre-update values)
    int n_store = 0;
    int n_input = 0;
    int n_cmp   = 0;
    int n_rst   = 0;

    always @(posedge clk) begin
        if (store_value) n_store++;
        if (input_value) n_input++;
        if (compare)     n_cmp++;
        if (input_reset) n_rst++;
    end

    // behavioural model
    int m_mode;
    int m_prog;
    int m_digits;
    int m_tries;

    // comparator plan for the next full submit: 0 correct, 1 incorrect,
    // 2 both flags, 3 no response
    int plan_outcome;
    int plan_delay;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_prog   = 0;
        m_digits = 0;
        m_tries  = MT;
    endtask

    task automatic lockout_check(input int first_cnt);
        int cnt;
        int s0;
        int i0;
        int c0;
        bit done;
        cnt  = first_cnt;
        s0   = n_store;
        i0   = n_input;
        c0   = n_cmp;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            store_btn  = 1'($urandom_range(0, 1));
            input_btn  = 1'($urandom_range(0, 1));
            submit_btn = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sleep) cnt++;
            else done = 1'b1;
        end
        store_btn  = 1'b0;
        input_btn  = 1'b0;
        submit_btn = 1'b0;
        check_val("lock_done", 32'(done), 32'd1);
        check_val("lock_len", cnt, LC);
        check_val("lock_exit_rst", 32'(input_reset), 32'd1);
        check_val("lock_tries", 32'(tries_left), MT);
        check_val("lock_no_store", n_store - s0, 0);
        check_val("lock_no_input", n_input - i0, 0);
        check_val("lock_no_cmp", n_cmp - c0, 0);
        m_mode  = M_IDLE;
        m_tries = MT;
        @(negedge clk);
    endtask

    // entered at a negedge with submit_btn just raised and a full attempt
    task automatic check_flow();
        int c0;
        int k;
        bit seen;
        c0 = n_cmp;
        @(negedge clk);
        check_val("cmp_early", 32'(compare), 32'd0);
        @(negedge clk);
        check_val("cmp_pulse", 32'(compare), 32'd1);
        check_val("cmp_digits", 32'(digit_count), 32'd0);
        submit_btn = 1'b0;
        m_digits   = 0;
        if (plan_outcome == 3) begin
            k    = 0;
            seen = 1'b0;
            while (k < 40 && !seen) begin
                @(negedge clk);
                k++;
                if (input_reset) seen = 1'b1;
            end
            check_val("to_seen", 32'(seen), 32'd1);
            check_val("to_lat", k, RT);
        end else begin
            repeat (plan_delay) @(negedge clk);
            correct_password   = (plan_outcome == 0 || plan_outcome == 2);
            incorrect_password = (plan_outcome == 1 || plan_outcome == 2);
            @(negedge clk);
            correct_password   = 1'b0;
            incorrect_password = 1'b0;
            check_val("res_rst", 32'(input_reset), (plan_outcome == 0) ? 32'd0 : 32'd1);
        end
        if (plan_outcome == 0) begin
            m_mode  = M_OPEN;
            m_tries = MT;
            check_val("open_unlock", 32'(unlock), 32'd1);
        end else begin
            m_tries = m_tries - 1;
            m_mode  = (m_tries == 0) ? M_LOCK : M_IDLE;
            check_val("fail_unlock", 32'(unlock), 32'd0);
        end
        check_val("res_tries", 32'(tries_left), m_tries);
        check_val("res_sleep", 32'(sleep), (m_mode == M_LOCK) ? 32'd1 : 32'd0);
        check_val("cmp_once", n_cmp - c0, 1);
        if (m_mode == M_LOCK) begin
            lockout_check(1);
        end else begin
            @(negedge clk);
            check_val("res_digits", 32'(digit_count), 32'd0);
        end
    endtask

    // act: 0 ignored, 1 store, 2 input, 3 failed attempt, 4 compare, 5 close
    task automatic press(input bit s, input bit i, input bit u);
        int sel;
        int act;
        int s0;
        int i0;
        int c0;
        int r0;
        int dc_first;
        sel = s ? 1 : i ? 2 : u ? 3 : 0;
        act = 0;
        case (m_mode)
            M_IDLE:  if (sel == 1) act = 1; else if (sel == 2 && m_prog != 0) act = 2;
            M_PROG:  if (sel == 1) act = 1;
            M_ENTRY: begin
                if (sel == 2 && m_digits < PL) act = 2;
                else if (sel == 3) act = (m_digits == PL) ? 4 : 3;
            end
            M_OPEN:  if (sel == 1) act = 1; else if (sel == 3) act = 5;
            default: act = 0;
        endcase
        if (act == 4) begin
            store_btn  = 1'b0;
            input_btn  = 1'b0;
            submit_btn = 1'b1;
            check_flow();
            return;
        end
        s0 = n_store;
        i0 = n_input;
        c0 = n_cmp;
        r0 = n_rst;
        store_btn  = s;
        input_btn  = i;
        submit_btn = u;
        dc_first   = m_digits;
        case (act)
            1: begin
                if (m_mode == M_PROG) begin
                    m_digits++;
                    dc_first = m_digits;
                    if (m_digits == PL) begin
                        m_prog   = 1;
                        m_digits = 0;
                        m_mode   = M_IDLE;
                    end
                end else begin
                    m_digits = 1;
                    dc_first = 1;
                    m_mode   = M_PROG;
                end
            end
            2: begin
                if (m_mode == M_IDLE) m_digits = 1;
                else m_digits++;
                m_mode   = M_ENTRY;
                dc_first = m_digits;
            end
            3: begin
                m_tries  = m_tries - 1;
                m_digits = 0;
                dc_first = 0;
                m_mode   = (m_tries == 0) ? M_LOCK : M_IDLE;
            end
            5: m_mode = M_IDLE;
            default: ;
        endcase
        @(negedge clk);
        check_val("p_store", 32'(store_value), (act == 1) ? 32'd1 : 32'd0);
        check_val("p_input", 32'(input_value), (act == 2) ? 32'd1 : 32'd0);
        check_val("p_rst", 32'(input_reset), (act == 3 || act == 5) ? 32'd1 : 32'd0);
        check_val("p_cmp", 32'(compare), 32'd0);
        check_val("p_digits", 32'(digit_count), dc_first);
        check_val("p_sleep", 32'(sleep), (m_mode == M_LOCK) ? 32'd1 : 32'd0);
        if (m_mode == M_LOCK) begin
            store_btn  = 1'b0;
            input_btn  = 1'b0;
            submit_btn = 1'b0;
            check_val("p_lock_tries", 32'(tries_left), 32'd0);
            lockout_check(1);
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        store_btn  = 1'b0;
        input_btn  = 1'b0;
        submit_btn = 1'b0;
        repeat (2) @(negedge clk);
        check_val("d_store", n_store - s0, (act == 1) ? 1 : 0);
        check_val("d_input", n_input - i0, (act == 2) ? 1 : 0);
        check_val("d_cmp", n_cmp - c0, 0);
        check_val("d_rst", n_rst - r0, (act == 3 || act == 5) ? 1 : 0);
        check_val("s_digits", 32'(digit_count), m_digits);
        check_val("s_tries", 32'(tries_left), m_tries);
        check_val("s_unlock", 32'(unlock), (m_mode == M_OPEN) ? 32'd1 : 32'd0);
        check_val("s_sleep", 32'(sleep), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int i0;
        int r;
        system_reset       = 1'b1;
        store_btn          = 1'b0;
        input_btn          = 1'b0;
        submit_btn         = 1'b0;
        correct_password   = 1'b0;
        incorrect_password = 1'b0;
        plan_outcome       = 0;
        plan_delay         = 2;
        model_reset();
        repeat (3) @(negedge clk);
        system_reset = 1'b0;
        @(negedge clk);

        check_val("rst_store", 32'(store_value), 32'd0);
        check_val("rst_input", 32'(input_value), 32'd0);
        check_val("rst_cmp", 32'(compare), 32'd0);
        check_val("rst_irst", 32'(input_reset), 32'd0);
        check_val("rst_unlock", 32'(unlock), 32'd0);
        check_val("rst_sleep", 32'(sleep), 32'd0);
        check_val("rst_digits", 32'(digit_count), 32'd0);
        check_val("rst_tries", 32'(tries_left), MT);

        // input before programming, then store+input together
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        repeat (PL - 1) press(1'b1, 1'b0, 1'b0);

        // correct code, result two cycles after compare, then close
        plan_outcome = 0;
        plan_delay   = 2;
        repeat (PL) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);

        // comparator never answers
        plan_outcome = 3;
        repeat (PL) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);

        // short submit
        repeat (2) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 160; n++) begin
            plan_outcome = $urandom_range(0, 3);
            plan_delay   = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: press(1'b1, 1'b0, 1'b0);
                3, 4, 5: press(1'b0, 1'b1, 1'b0);
                6, 7:    press(1'b0, 1'b0, 1'b1);
                8:       press(1'b1, 1'b1, 1'b0);
                default: press(1'b0, 1'b1, 1'b1);
            endcase
        end

        // reset during lockout with input held
        system_reset = 1'b1;
        @(negedge clk);
        system_reset = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (PL) press(1'b1, 1'b0, 1'b0);
        while (m_tries > 1) begin
            press(1'b0, 1'b1, 1'b0);
            press(1'b0, 1'b0, 1'b1);
        end
        press(1'b0, 1'b1, 1'b0);
        submit_btn = 1'b1;
        @(negedge clk);
        check_val("rl_sleep_in", 32'(sleep), 32'd1);
        check_val("rl_tries0", 32'(tries_left), 32'd0);
        submit_btn = 1'b0;
        input_btn  = 1'b1;
        repeat (4) @(negedge clk);
        check_val("rl_sleep_mid", 32'(sleep), 32'd1);
        system_reset = 1'b1;
        @(negedge clk);
        check_val("rl_sleep", 32'(sleep), 32'd0);
        check_val("rl_tries", 32'(tries_left), MT);
        check_val("rl_digits", 32'(digit_count), 32'd0);
        check_val("rl_unlock", 32'(unlock), 32'd0);
        i0 = n_input;
        system_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rl_no_input", n_input - i0, 0);
        input_btn = 1'b0;
        @(negedge clk);
        // programmed flag was cleared: an input press does nothing
        press(1'b0, 1'b1, 1'b0);

        // store pressed during reset and held past it
        system_reset = 1'b1;
        store_btn    = 1'b1;
        @(negedge clk);
        s0 = n_store;
        system_reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_held_store", n_store - s0, 0);
        check_val("rst_held_digits", 32'(digit_count), 32'd0);
        store_btn = 1'b0;
        @(negedge clk);
        model_reset();
        press(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
